// File: rtl/add_tree_operand_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add_tree_operand_loader_if : word stream in, parallel operand frame out
// Revision : 1.0
// ---------------------------------------------------------------------------
interface add_tree_operand_loader_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_00, out_01, out_02, out_03, out_04, out_05, out_06;
  logic [DATA_W-1:0] out_07, out_08, out_09, out_10, out_11, out_12, out_13;
  logic [DATA_W-1:0] out_14, out_15, out_16, out_17, out_18, out_19, out_20;
  logic [DATA_W-1:0] out_21, out_22, out_23, out_24, out_25;
  logic              err_short;
  logic              err_long;
  logic [15:0]       frame_cnt;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, err_short, err_long, frame_cnt,
    input  out_00, out_01, out_02, out_03, out_04, out_05, out_06,
    input  out_07, out_08, out_09, out_10, out_11, out_12, out_13,
    input  out_14, out_15, out_16, out_17, out_18, out_19, out_20,
    input  out_21, out_22, out_23, out_24, out_25
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, err_short, err_long, frame_cnt,
    output out_00, out_01, out_02, out_03, out_04, out_05, out_06,
    output out_07, out_08, out_09, out_10, out_11, out_12, out_13,
    output out_14, out_15, out_16, out_17, out_18, out_19, out_20,
    output out_21, out_22, out_23, out_24, out_25
  );
endinterface
`default_nettype wire

// File: rtl/add_tree_operand_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add_tree_operand_loader : serial-to-parallel, double-buffered operand loader
// Revision : 1.0
// ---------------------------------------------------------------------------
module add_tree_operand_loader #(
  parameter int DATA_W = 16,
  parameter int N_OPS  = 26
) (
  input wire logic                 clk,
  input wire logic                 rst,
  add_tree_operand_loader_if.slave bus
);
  localparam int                CNT_W      = $clog2(N_OPS);
  localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(N_OPS - 1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_err_short;
  logic              r_err_long;
  logic [15:0]       r_frame_cnt;
  logic [DATA_W-1:0] r_shadow [N_OPS];
  logic [DATA_W-1:0] r_out    [N_OPS];
  logic [DATA_W-1:0] w_frame  [N_OPS];

  logic w_accept;
  logic w_complete;
  logic w_out_free;
  logic w_xfer_in;
  logic w_xfer_shadow;
  logic w_hold;

  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_complete = w_accept & (bus.in_last | (r_cnt == c_LAST_IDX));
  assign w_out_free = ~r_out_valid | bus.out_ready;

  // Completed frame as seen on the completion edge: earlier slots from the
  // shadow bank, the current word in its slot, and zeros past it.
  generate
    for (genvar i = 0; i < N_OPS; i++) begin : g_frame
      localparam logic [CNT_W-1:0] c_IDX = CNT_W'(i);
      assign w_frame[i] = (c_IDX < r_cnt)  ? r_shadow[i] :
                          (c_IDX == r_cnt) ? bus.in_data : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_xfer_in     = 1'b0;
    w_xfer_shadow = 1'b0;
    w_hold        = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_complete) begin
          if (w_out_free) begin
            w_xfer_in = 1'b1;
          end else begin
            w_hold       = 1'b1;
            w_state_next = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          w_xfer_shadow = 1'b1;
          w_state_next  = ST_FILL;
        end
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_frame_cnt <= '0;
      for (int i = 0; i < N_OPS; i++) begin
        r_shadow[i] <= '0;
        r_out[i]    <= '0;
      end
    end else begin
      r_in_ready  <= (w_state_next == ST_FILL);
      r_err_short <= w_complete & bus.in_last & (r_cnt != c_LAST_IDX);
      r_err_long  <= w_complete & ~bus.in_last;

      if (w_accept) begin
        r_cnt <= w_complete ? '0 : r_cnt + 1'b1;
        if (!w_complete) r_shadow[r_cnt] <= bus.in_data;
      end
      if (w_hold) begin
        for (int i = 0; i < N_OPS; i++) r_shadow[i] <= w_frame[i];
      end

      if (w_xfer_in) begin
        for (int i = 0; i < N_OPS; i++) r_out[i] <= w_frame[i];
      end else if (w_xfer_shadow) begin
        for (int i = 0; i < N_OPS; i++) r_out[i] <= r_shadow[i];
      end

      if (w_xfer_in | w_xfer_shadow) begin
        r_out_valid <= 1'b1;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.err_short = r_err_short;
  assign bus.err_long  = r_err_long;
  assign bus.frame_cnt = r_frame_cnt;

  assign bus.out_00 = r_out[0];   assign bus.out_01 = r_out[1];
  assign bus.out_02 = r_out[2];   assign bus.out_03 = r_out[3];
  assign bus.out_04 = r_out[4];   assign bus.out_05 = r_out[5];
  assign bus.out_06 = r_out[6];   assign bus.out_07 = r_out[7];
  assign bus.out_08 = r_out[8];   assign bus.out_09 = r_out[9];
  assign bus.out_10 = r_out[10];  assign bus.out_11 = r_out[11];
  assign bus.out_12 = r_out[12];  assign bus.out_13 = r_out[13];
  assign bus.out_14 = r_out[14];  assign bus.out_15 = r_out[15];
  assign bus.out_16 = r_out[16];  assign bus.out_17 = r_out[17];
  assign bus.out_18 = r_out[18];  assign bus.out_19 = r_out[19];
  assign bus.out_20 = r_out[20];  assign bus.out_21 = r_out[21];
  assign bus.out_22 = r_out[22];  assign bus.out_23 = r_out[23];
  assign bus.out_24 = r_out[24];  assign bus.out_25 = r_out[25];
endmodule
`default_nettype wire

// File: tb/tb_add_tree_operand_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_add_tree_operand_loader : directed + random frames against a frame model
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_add_tree_operand_loader;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  add_tree_operand_loader_if #(.DATA_W(16)) bus ();

  add_tree_operand_loader #(.DATA_W(16), .N_OPS(26)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] obs [26];
  assign obs[0]  = bus.out_00;  assign obs[1]  = bus.out_01;  assign obs[2]  = bus.out_02;
  assign obs[3]  = bus.out_03;  assign obs[4]  = bus.out_04;  assign obs[5]  = bus.out_05;
  assign obs[6]  = bus.out_06;  assign obs[7]  = bus.out_07;  assign obs[8]  = bus.out_08;
  assign obs[9]  = bus.out_09;  assign obs[10] = bus.out_10;  assign obs[11] = bus.out_11;
  assign obs[12] = bus.out_12;  assign obs[13] = bus.out_13;  assign obs[14] = bus.out_14;
  assign obs[15] = bus.out_15;  assign obs[16] = bus.out_16;  assign obs[17] = bus.out_17;
  assign obs[18] = bus.out_18;  assign obs[19] = bus.out_19;  assign obs[20] = bus.out_20;
  assign obs[21] = bus.out_21;  assign obs[22] = bus.out_22;  assign obs[23] = bus.out_23;
  assign obs[24] = bus.out_24;  assign obs[25] = bus.out_25;

  // Frame-level reference: words collect in a queue, a finished frame goes
  // to the output bank if it is free, otherwise it waits as the pending frame.
  logic [15:0] exp_out [26];
  logic [15:0] pend    [26];
  logic [15:0] cur_q   [$];
  bit          pend_vld;
  bit          exp_in_ready, exp_valid, exp_es, exp_el, m_acc;
  logic [15:0] exp_fc;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_edge(input bit r_st, input bit v, input logic [15:0] d,
                            input bit l, input bit rdy);
    bit          free, xfer;
    logic [15:0] fr [26];
    m_acc  = 1'b0;
    exp_es = 1'b0;
    exp_el = 1'b0;
    if (r_st) begin
      exp_in_ready = 1'b0;
      exp_valid    = 1'b0;
      exp_fc       = '0;
      pend_vld     = 1'b0;
      cur_q.delete();
      for (int i = 0; i < 26; i++) exp_out[i] = '0;
      return;
    end
    free = !exp_valid || rdy;
    xfer = 1'b0;
    if (pend_vld) begin
      if (rdy) begin
        exp_out  = pend;
        pend_vld = 1'b0;
        xfer     = 1'b1;
      end
    end else if (exp_in_ready && v) begin
      m_acc = 1'b1;
      cur_q.push_back(d);
      if (l || cur_q.size() == 26) begin
        for (int i = 0; i < 26; i++) fr[i] = (i < cur_q.size()) ? cur_q[i] : 16'h0000;
        exp_es = l && (cur_q.size() < 26);
        exp_el = !l && (cur_q.size() == 26);
        cur_q.delete();
        if (free) begin
          exp_out = fr;
          xfer    = 1'b1;
        end else begin
          pend     = fr;
          pend_vld = 1'b1;
        end
      end
    end
    if (xfer) begin
      exp_valid = 1'b1;
      exp_fc    = exp_fc + 16'd1;
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
    exp_in_ready = !pend_vld;
  endtask

  task automatic check_all();
    chk("in_ready",  bus.in_ready,  exp_in_ready);
    chk("out_valid", bus.out_valid, exp_valid);
    chk("err_short", bus.err_short, exp_es);
    chk("err_long",  bus.err_long,  exp_el);
    chk("frame_cnt", bus.frame_cnt, exp_fc);
    for (int i = 0; i < 26; i++) chk($sformatf("out_%02d", i), obs[i], exp_out[i]);
  endtask

  task automatic cyc(input bit r_st, input bit v, input logic [15:0] d,
                     input bit l, input bit rdy);
    rst           = r_st;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge(r_st, v, d, l, rdy);
    @(negedge clk);
    check_all();
  endtask

  // mode 0: k, 1: -k, 2: -k below 13 else k, other: random
  task automatic send_words(input int n, input int last_at, input int mode, input bit rdy);
    int          k;
    int          guard;
    logic [15:0] d;
    k     = 0;
    guard = 0;
    while (k < n && guard < 200) begin
      case (mode)
        0:       d = 16'(k);
        1:       d = 16'(-k);
        2:       d = (k < 13) ? 16'(-k) : 16'(k);
        default: d = 16'($urandom);
      endcase
      cyc(1'b0, 1'b1, d, (k == last_at), rdy);
      if (m_acc) k++;
      guard++;
    end
    chk("send_progress", k, n);
  endtask

  initial begin
    int sum;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    cyc(1, 0, 16'h0, 0, 0);
    cyc(1, 1, 16'h1234, 1, 1);
    cyc(0, 0, 16'h0, 0, 0);

    // Ramp frame; the tree sum of 0..25 is 325.
    send_words(26, 25, 0, 1);
    chk("ramp_valid", bus.out_valid, 1);
    chk("ramp_fc", bus.frame_cnt, 16'd1);
    sum = 0;
    for (int i = 0; i < 26; i++) sum += int'($signed(obs[i]));
    chk("tree_sum", sum, 325);

    // Negative ramp, then mixed signs.
    send_words(26, 25, 1, 1);
    chk("neg_slot1", obs[1], 16'hFFFF);
    chk("neg_slot25", obs[25], 16'hFFE7);
    send_words(26, 25, 2, 1);
    chk("mix_slot12", obs[12], 16'hFFF4);
    chk("mix_slot13", obs[13], 16'h000D);

    // Back-to-back with output stalled: second frame waits in the shadow bank.
    send_words(26, 25, 3, 1);
    send_words(26, 25, 3, 0);
    chk("full_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'($urandom), 1, 0);
    cyc(0, 1, 16'hBEEF, 1, 1);
    chk("full_release_valid", bus.out_valid, 1);
    chk("full_release_ready", bus.in_ready, 1);
    cyc(0, 0, 16'h0, 0, 0);
    cyc(0, 0, 16'h0, 0, 1);

    // Short frame ending on word 9.
    send_words(10, 9, 3, 1);
    chk("short_pulse", bus.err_short, 1);
    chk("short_pad", obs[10], 16'h0000);
    cyc(0, 0, 16'h0, 0, 1);
    chk("short_pulse_end", bus.err_short, 0);

    // Long frame, then a one-word frame that must land in slot 0.
    send_words(26, -1, 3, 1);
    chk("long_pulse", bus.err_long, 1);
    send_words(1, 0, 3, 1);
    chk("after_long_pad", obs[1], 16'h0000);

    // Reset mid-frame and while holding a full shadow bank.
    send_words(12, -1, 0, 1);
    cyc(1, 1, 16'h5555, 0, 0);
    cyc(0, 0, 16'h0, 0, 0);
    send_words(26, 25, 0, 1);
    send_words(26, 25, 3, 0);
    cyc(1, 0, 16'h0, 0, 0);
    chk("rst_full_valid", bus.out_valid, 0);
    cyc(0, 0, 16'h0, 0, 0);
    send_words(26, 25, 2, 1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      cyc(($urandom % 151) == 0, ($urandom % 4) != 0, 16'($urandom),
          ($urandom % 10) == 0, ($urandom % 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
